msrv32_dmem_slave: RTL and testbench



---
 rtl/msrv32_dmem_slave.sv | 145 ++++++++++++++
 tb/tb_msrv32_dmem_slave.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_dmem_slave.sv
// Data-memory responder for the msrv32 AHB-lite-style data port: word-addressed RAM
// with byte-lane writes, configurable wait states and a two-cycle ERROR response.
module msrv32_dmem_slave #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [31:0] ms_riscv32_mp_dmaddr_in,
    input  logic [31:0] ms_riscv32_mp_dmdata_in,
    input  logic        ms_riscv32_mp_dmwr_req_in,
    input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
    input  logic [1:0]  ms_riscv32_mp_data_htrans_in,
    output logic [31:0] ms_riscv32_mp_data_out,
    output logic        ms_riscv32_mp_data_hready_out,
    output logic        ms_riscv32_mp_hresp_out
);

    localparam int unsigned AW     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'(DEPTH_WORDS) * 33'd4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      mask_q, mask_d;
    logic            wr_q, wr_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [31:0]     mem [0:DEPTH_WORDS-1];

    logic            hready;
    logic            accept;
    logic            in_win;
    logic [AW-1:0]   new_idx;
    logic            commit;
    logic [31:0]     commit_word;
    logic [31:0]     rd_word;

    always_comb begin
        hready  = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
        accept  = ms_riscv32_mp_data_htrans_in[1] && hready;
        in_win  = ({1'b0, ms_riscv32_mp_dmaddr_in} >= WIN_LO) &&
                  ({1'b0, ms_riscv32_mp_dmaddr_in} <  WIN_HI);
        new_idx = ms_riscv32_mp_dmaddr_in[AW+1:2];
        // A write lands at the edge that ends DATA; reset on that edge cancels it.
        commit  = (state_q == S_DATA) && wr_q && !ms_riscv32_mp_rst_in;
    end

    // Merged word the committing write produces; feeds the same-edge read bypass.
    always_comb begin
        commit_word = mem[idx_q];
        for (int i = 0; i < 4; i++) begin
            if (mask_q[i]) begin
                commit_word[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
        rd_word = (commit && (idx_q == new_idx)) ? commit_word : mem[new_idx];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;

        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            idx_d   = new_idx;
            wdata_d = ms_riscv32_mp_dmdata_in;
            mask_d  = ms_riscv32_mp_dmwr_mask_in;
            wr_d    = ms_riscv32_mp_dmwr_req_in;
            if (!in_win) begin
                state_d = S_ERR1;
            end else begin
                if (WAIT_STATES > 0) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(WAIT_STATES - 1);
                end else begin
                    state_d = S_DATA;
                end
                if (!ms_riscv32_mp_dmwr_req_in) begin
                    rdata_d = rd_word;
                end
            end
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Captured transfer fields are only meaningful alongside state, so they need no reset.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        mask_q  <= mask_d;
        wr_q    <= wr_d;
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        for (int i = 0; i < 4; i++) begin
            if (commit && mask_q[i]) begin
                mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign ms_riscv32_mp_data_out        = rdata_q;
    assign ms_riscv32_mp_data_hready_out = hready;
    assign ms_riscv32_mp_hresp_out       = (state_q == S_ERR1) || (state_q == S_ERR2);

endmodule

// File: tb/tb_msrv32_dmem_slave.sv
// Bench for msrv32_dmem_slave: a zero-wait instance driven from a vector table and a
// three-wait instance driven by hand-written multi-cycle sequences.
module tb_msrv32_dmem_slave;

    localparam logic [1:0] HT_IDLE = 2'b00;
    localparam logic [1:0] HT_BUSY = 2'b01;
    localparam logic [1:0] HT_NSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] a0_addr, a0_wdata, d0_out;
    logic        a0_wr, d0_rdy, d0_resp;
    logic [3:0]  a0_mask;
    logic [1:0]  a0_ht;

    logic [31:0] a3_addr, a3_wdata, d3_out;
    logic        a3_wr, d3_rdy, d3_resp;
    logic [3:0]  a3_mask;
    logic [1:0]  a3_ht;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    msrv32_dmem_slave #(
        .DEPTH_WORDS(64),
        .WAIT_STATES(0),
        .BASE_ADDR  (32'h0000_0000)
    ) u_dut0 (
        .ms_riscv32_mp_clk_in         (clk),
        .ms_riscv32_mp_rst_in         (rst),
        .ms_riscv32_mp_dmaddr_in      (a0_addr),
        .ms_riscv32_mp_dmdata_in      (a0_wdata),
        .ms_riscv32_mp_dmwr_req_in    (a0_wr),
        .ms_riscv32_mp_dmwr_mask_in   (a0_mask),
        .ms_riscv32_mp_data_htrans_in (a0_ht),
        .ms_riscv32_mp_data_out       (d0_out),
        .ms_riscv32_mp_data_hready_out(d0_rdy),
        .ms_riscv32_mp_hresp_out      (d0_resp)
    );

    msrv32_dmem_slave #(
        .DEPTH_WORDS(64),
        .WAIT_STATES(3),
        .BASE_ADDR  (32'h0000_0400)
    ) u_dut3 (
        .ms_riscv32_mp_clk_in         (clk),
        .ms_riscv32_mp_rst_in         (rst),
        .ms_riscv32_mp_dmaddr_in      (a3_addr),
        .ms_riscv32_mp_dmdata_in      (a3_wdata),
        .ms_riscv32_mp_dmwr_req_in    (a3_wr),
        .ms_riscv32_mp_dmwr_mask_in   (a3_mask),
        .ms_riscv32_mp_data_htrans_in (a3_ht),
        .ms_riscv32_mp_data_out       (d3_out),
        .ms_riscv32_mp_data_hready_out(d3_rdy),
        .ms_riscv32_mp_hresp_out      (d3_resp)
    );

    typedef struct {
        logic [1:0]  ht;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_data;
    } vec_t;

    vec_t vt [18];

    function automatic vec_t mk(input logic [1:0] ht, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] mask,
                                input logic e_rdy, input logic e_resp, input logic [31:0] e_data);
        vec_t v;
        v.ht = ht; v.wr = wr; v.addr = addr; v.wdata = wdata; v.mask = mask;
        v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_data = e_data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv3(input logic [1:0] ht, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask);
        a3_ht = ht; a3_wr = wr; a3_addr = addr; a3_wdata = wdata; a3_mask = mask;
    endtask

    // Present one transfer to the three-wait instance for a single edge, then go idle.
    task automatic xfer3(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask);
        drv3(HT_NSEQ, wr, addr, wdata, mask);
        step();
        drv3(HT_IDLE, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Checks a full 4-cycle okay data phase (3 wait cycles then DATA); ends in DATA.
    task automatic phase3(input string name, input logic [31:0] e_data);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) step();
            chk($sformatf("%s.c%0d.hready", name, c), 32'(d3_rdy), (c < 3) ? 32'd0 : 32'd1);
            chk($sformatf("%s.c%0d.hresp", name, c), 32'(d3_resp), 32'd0);
            chk($sformatf("%s.c%0d.data", name, c), d3_out, e_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a0_ht = HT_IDLE; a0_wr = 1'b0; a0_addr = '0; a0_wdata = '0; a0_mask = '0;
        drv3(HT_IDLE, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) step();
        rst = 1'b0;
        chk("rst.d0.hready", 32'(d0_rdy), 32'd1);
        chk("rst.d0.hresp", 32'(d0_resp), 32'd0);
        chk("rst.d0.data", d0_out, 32'h0);
        chk("rst.d3.hready", 32'(d3_rdy), 32'd1);
        chk("rst.d3.hresp", 32'(d3_resp), 32'd0);
        chk("rst.d3.data", d3_out, 32'h0);

        // Zero-wait table: each row is sampled at one edge, outputs checked just after it.
        vt[0]  = mk(HT_NSEQ, 1'b1, 32'h10,  32'hDEADBEEF, 4'b1111, 1'b1, 1'b0, 32'h0);
        vt[1]  = mk(HT_NSEQ, 1'b0, 32'h10,  32'h0,        4'b0000, 1'b1, 1'b0, 32'hDEADBEEF);
        vt[2]  = mk(HT_NSEQ, 1'b1, 32'h20,  32'h11223344, 4'b1111, 1'b1, 1'b0, 32'hDEADBEEF);
        vt[3]  = mk(HT_NSEQ, 1'b1, 32'h20,  32'hAABBCCDD, 4'b0101, 1'b1, 1'b0, 32'hDEADBEEF);
        vt[4]  = mk(HT_NSEQ, 1'b0, 32'h20,  32'h0,        4'b0000, 1'b1, 1'b0, 32'h11BB33DD);
        vt[5]  = mk(HT_IDLE, 1'b1, 32'h10,  32'h0,        4'b1111, 1'b1, 1'b0, 32'h11BB33DD);
        vt[6]  = mk(HT_BUSY, 1'b1, 32'h10,  32'h0,        4'b1111, 1'b1, 1'b0, 32'h11BB33DD);
        vt[7]  = mk(HT_BUSY, 1'b1, 32'h10,  32'h0,        4'b1111, 1'b1, 1'b0, 32'h11BB33DD);
        vt[8]  = mk(HT_SEQ,  1'b0, 32'h10,  32'h0,        4'b0000, 1'b1, 1'b0, 32'hDEADBEEF);
        vt[9]  = mk(HT_NSEQ, 1'b1, 32'h10,  32'h0,        4'b0000, 1'b1, 1'b0, 32'hDEADBEEF);
        vt[10] = mk(HT_NSEQ, 1'b0, 32'h10,  32'h0,        4'b0000, 1'b1, 1'b0, 32'hDEADBEEF);
        vt[11] = mk(HT_NSEQ, 1'b1, 32'h00,  32'hCAFEF00D, 4'b1111, 1'b1, 1'b0, 32'hDEADBEEF);
        vt[12] = mk(HT_NSEQ, 1'b1, 32'h100, 32'h12345678, 4'b1111, 1'b0, 1'b1, 32'hDEADBEEF);
        vt[13] = mk(HT_NSEQ, 1'b0, 32'h10,  32'h0,        4'b0000, 1'b1, 1'b1, 32'hDEADBEEF);
        vt[14] = mk(HT_NSEQ, 1'b0, 32'h00,  32'h0,        4'b0000, 1'b1, 1'b0, 32'hCAFEF00D);
        vt[15] = mk(HT_NSEQ, 1'b0, 32'h100, 32'h0,        4'b0000, 1'b0, 1'b1, 32'hCAFEF00D);
        vt[16] = mk(HT_IDLE, 1'b0, 32'h0,   32'h0,        4'b0000, 1'b1, 1'b1, 32'hCAFEF00D);
        vt[17] = mk(HT_IDLE, 1'b0, 32'h0,   32'h0,        4'b0000, 1'b1, 1'b0, 32'hCAFEF00D);

        for (int i = 0; i < 18; i++) begin
            a0_ht = vt[i].ht; a0_wr = vt[i].wr; a0_addr = vt[i].addr;
            a0_wdata = vt[i].wdata; a0_mask = vt[i].mask;
            step();
            chk($sformatf("v%0d.hready", i), 32'(d0_rdy), 32'(vt[i].e_rdy));
            chk($sformatf("v%0d.hresp", i), 32'(d0_resp), 32'(vt[i].e_resp));
            chk($sformatf("v%0d.data", i), d0_out, vt[i].e_data);
        end
        a0_ht = HT_IDLE; a0_wr = 1'b0;

        // Three-wait write, then back-to-back read of the same word.
        xfer3(1'b1, 32'h440, 32'h55AA55AA, 4'b1111);
        phase3("ws.wr", 32'h0);
        xfer3(1'b0, 32'h440, 32'h0, 4'b0000);
        phase3("ws.rd", 32'h55AA55AA);
        step();

        // Reset in the middle of a waited write.
        xfer3(1'b1, 32'h440, 32'h0BADF00D, 4'b1111);
        chk("mid.wait.hready", 32'(d3_rdy), 32'd0);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("mid.rst%0d.hready", c), 32'(d3_rdy), 32'd1);
            chk($sformatf("mid.rst%0d.hresp", c), 32'(d3_resp), 32'd0);
            chk($sformatf("mid.rst%0d.data", c), d3_out, 32'h0);
        end
        rst = 1'b0;
        xfer3(1'b0, 32'h440, 32'h0, 4'b0000);
        phase3("mid.rd", 32'h55AA55AA);
        step();

        // Out-of-window read just past the top, a write to an aliased index, and below base.
        xfer3(1'b0, 32'h500, 32'h0, 4'b0000);
        chk("oow.rd.c1.hready", 32'(d3_rdy), 32'd0);
        chk("oow.rd.c1.hresp", 32'(d3_resp), 32'd1);
        chk("oow.rd.c1.data", d3_out, 32'h55AA55AA);
        step();
        chk("oow.rd.c2.hready", 32'(d3_rdy), 32'd1);
        chk("oow.rd.c2.hresp", 32'(d3_resp), 32'd1);
        step();
        chk("oow.rd.c3.hready", 32'(d3_rdy), 32'd1);
        chk("oow.rd.c3.hresp", 32'(d3_resp), 32'd0);

        xfer3(1'b1, 32'h540, 32'hFFFFFFFF, 4'b1111);
        chk("oow.wr.c1.hready", 32'(d3_rdy), 32'd0);
        chk("oow.wr.c1.hresp", 32'(d3_resp), 32'd1);
        step();
        chk("oow.wr.c2.hready", 32'(d3_rdy), 32'd1);
        chk("oow.wr.c2.hresp", 32'(d3_resp), 32'd1);
        step();
        xfer3(1'b0, 32'h440, 32'h0, 4'b0000);
        phase3("oow.alias", 32'h55AA55AA);
        step();

        xfer3(1'b0, 32'h3FC, 32'h0, 4'b0000);
        chk("low.c1.hready", 32'(d3_rdy), 32'd0);
        chk("low.c1.hresp", 32'(d3_resp), 32'd1);
        step();
        chk("low.c2.hready", 32'(d3_rdy), 32'd1);
        chk("low.c2.hresp", 32'(d3_resp), 32'd1);
        chk("low.c2.data", d3_out, 32'h55AA55AA);
        step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
